// File: rtl/sr_input_conditioner_pkg.sv
// sr_cond_pkg -- shared types and constants for the sr_input_conditioner slice.
//
// Contents:
//   sr_cond_state_t   : arbitration FSM states (IDLE, DRIVE_S, DRIVE_R, HOLDOFF)
//   SR_HOLDOFF_CYCLES : quiet cycles forced between two output pulses
package sr_cond_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE_S = 2'd1,
        DRIVE_R = 2'd2,
        HOLDOFF = 2'd3
    } sr_cond_state_t;

    localparam int SR_HOLDOFF_CYCLES = 1;

endpackage

// File: rtl/sr_input_conditioner_if.sv
// sr_input_conditioner_if -- groups the raw request lines and the conditioned
// flip-flop drive signals of sr_input_conditioner.
//
// Signals:
//   set_in, clr_in : raw (possibly bouncing) set / clear requests
//   s, r           : clean, mutually exclusive drive pulses to the flip-flop
//   busy           : arbitration FSM is not idle
//   conflict       : one-cycle pulse when simultaneous requests are discarded
//
// Modports:
//   master : the request source / observer of the conditioned outputs
//   slave  : the conditioner itself
interface sr_input_conditioner_if;

    logic set_in;
    logic clr_in;
    logic s;
    logic r;
    logic busy;
    logic conflict;

    modport master (
        output set_in,
        output clr_in,
        input  s,
        input  r,
        input  busy,
        input  conflict
    );

    modport slave (
        input  set_in,
        input  clr_in,
        output s,
        output r,
        output busy,
        output conflict
    );

endinterface

// File: rtl/sr_input_conditioner_debounce.sv
// sr_debounce -- single-channel debouncer with rising-edge detect.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   din  : raw level input
//   deb  : debounced level
//   rise : high for one cycle after deb goes 0 -> 1
//
// Build option: define SR_INPUT_SYNC_EN to place a 2-flop synchronizer in
// front of the debouncer (adds 2 cycles of latency).
module sr_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic deb,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sample;
    logic [CNT_W-1:0] cnt;
    logic             deb_d;

`ifdef SR_INPUT_SYNC_EN
    logic sync_a;
    logic sync_b;

    // Two-stage synchronizer for inputs from another clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= din;
            sync_b <= sync_a;
        end
    end

    assign sample = sync_b;
`else
    assign sample = din;
`endif

    // Any sample that agrees with the current level restarts the count, so
    // only an unbroken run of DEBOUNCE_CYCLES differing samples flips deb.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
        end else begin
            deb_d <= deb;
            if (sample == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= sample;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign rise = deb & ~deb_d;

endmodule

// File: rtl/sr_input_conditioner.sv
// sr_input_conditioner -- debounces raw set/clear requests and drives an SR
// flip-flop with clean, fixed-width, never-overlapping s/r pulses.
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : sr_input_conditioner_if.slave (set_in, clr_in in; s, r, busy,
//         conflict out)
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive differing samples to change a level (>=1)
//   PULSE_W         : cycles s or r is held high per request (>=1)
//
// Build option: SR_INPUT_SYNC_EN adds a 2-flop synchronizer per input.
module sr_input_conditioner
    import sr_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_W         = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    sr_input_conditioner_if.slave  bus
);

    localparam int PCNT_MAX = (PULSE_W > SR_HOLDOFF_CYCLES) ? PULSE_W : SR_HOLDOFF_CYCLES;
    localparam int PCNT_W   = $clog2(PCNT_MAX + 1);
    localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_W - 1);
    localparam logic [PCNT_W-1:0] HOLD_LAST  = PCNT_W'(SR_HOLDOFF_CYCLES - 1);

    sr_cond_state_t    state;
    sr_cond_state_t    next_state;
    logic [PCNT_W-1:0] pcnt;
    logic [PCNT_W-1:0] pcnt_next;

    logic rise_set;
    logic rise_clr;
    logic pend_set;
    logic pend_clr;
    logic take_set;
    logic take_clr;
    logic conflict_next;

    // Only the edges matter here; the debounced levels are left unused.
    logic set_level_unused;
    logic clr_level_unused;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.set_in),
        .deb  (set_level_unused),
        .rise (rise_set)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.clr_in),
        .deb  (clr_level_unused),
        .rise (rise_clr)
    );

    // FSM state and the shared pulse/holdoff counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pcnt  <= '0;
        end else begin
            state <= next_state;
            pcnt  <= pcnt_next;
        end
    end

    // Arbitration: simultaneous requests cancel each other, otherwise the
    // single pending request is served. The counter restarts at 0 on every
    // state change so it can time both DRIVE and HOLDOFF.
    always_comb begin
        next_state    = state;
        pcnt_next     = '0;
        take_set      = 1'b0;
        take_clr      = 1'b0;
        conflict_next = 1'b0;
        case (state)
            IDLE: begin
                if (pend_set && pend_clr) begin
                    conflict_next = 1'b1;
                    take_set      = 1'b1;
                    take_clr      = 1'b1;
                end else if (pend_set) begin
                    take_set   = 1'b1;
                    next_state = DRIVE_S;
                end else if (pend_clr) begin
                    take_clr   = 1'b1;
                    next_state = DRIVE_R;
                end
            end
            DRIVE_S, DRIVE_R: begin
                if (pcnt == PULSE_LAST) begin
                    next_state = HOLDOFF;
                end else begin
                    pcnt_next = pcnt + PCNT_W'(1);
                end
            end
            HOLDOFF: begin
                if (pcnt == HOLD_LAST) begin
                    next_state = IDLE;
                end else begin
                    pcnt_next = pcnt + PCNT_W'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Pending latches and output registers. A new edge arriving on the same
    // cycle its previous request is taken is kept as a fresh request. s and r
    // are decoded from the next state so they change together with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_set     <= 1'b0;
            pend_clr     <= 1'b0;
            bus.s        <= 1'b0;
            bus.r        <= 1'b0;
            bus.conflict <= 1'b0;
        end else begin
            pend_set     <= rise_set | (pend_set & ~take_set);
            pend_clr     <= rise_clr | (pend_clr & ~take_clr);
            bus.s        <= (next_state == DRIVE_S);
            bus.r        <= (next_state == DRIVE_R);
            bus.conflict <= conflict_next;
        end
    end

    assign bus.busy = (state != IDLE);

endmodule

// File: doc/sr_input_conditioner.md
# sr_input_conditioner

Upstream conditioning stage for the `srflipflop` block. It takes two raw, possibly bouncing request lines (set and clear), debounces each one and latches their rising edges as pending requests. It then arbitrates between them and drives the flip-flop's `s`/`r` inputs with clean, mutually exclusive, fixed-width pulses. The forbidden `s=r=1` combination can never reach the flip-flop.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive differing samples needed before a debounced level changes; legal range ≥1.
- `PULSE_W`, default 1: cycles that `s` or `r` is held high per request; legal range ≥1.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: reset, synchronous and active-high.
- `set_in  in  1`: raw set request; level input, may bounce.
- `clr_in  in  1`: raw clear request; level input, may bounce.
- `s  out  1`: set drive to the flip-flop; registered.
- `r  out  1`: reset drive to the flip-flop; registered.
- `busy  out  1`: high when the FSM is not in IDLE.
- `conflict  out  1`: one-cycle pulse when simultaneous set and clear requests are discarded.

## Operation
- **Debounce, per channel.** State is a counter `cnt` of width $clog2(DEBOUNCE_CYCLES+1) and a debounced level `deb`.
  - If sample == `deb`: `cnt` <= 0.
  - Otherwise `cnt` increments. When it would reach `DEBOUNCE_CYCLES`, `deb` <= sample and `cnt` <= 0.
- **Edge latch.** A rising edge of `deb` (`deb`=1 while its delayed copy is 0) sets `pend` on that channel.
  - `pend` clears only when the FSM serves or discards it.
  - Repeated edges while `pend` is already set merge into the one request.
  - Falling edges of `deb` are ignored.
- **FSM states:** IDLE, DRIVE_S, DRIVE_R, HOLDOFF.
- **IDLE transitions:**
  - Both `pend` set: pulse `conflict`, clear both `pend`, stay in IDLE.
  - Only set `pend`: clear it, go to DRIVE_S.
  - Only clear `pend`: clear it, go to DRIVE_R.
- **DRIVE_S / DRIVE_R:**
  - Held for `PULSE_W` cycles, counted by a pulse counter.
  - `s`=1 only in DRIVE_S; `r`=1 only in DRIVE_R.
  - Then go to HOLDOFF.
- **HOLDOFF:**
  - One cycle with `s`=`r`=0, then IDLE.
  - Requests arriving during DRIVE or HOLDOFF stay pending and are arbitrated on return to IDLE.
- **Invariant:** `s & r` is 0 in every cycle, including reset.

## Timing
- **Reset values:** `s`=0, `r`=0, `busy`=0, `conflict`=0. Internally: `deb`=0, `cnt`=0, `pend`=0, state IDLE.
- **Reset mid-operation:** a reset during DRIVE aborts the pulse; outputs are low after that same edge and all pending requests are lost.
- **Latency, counting E1 as the first edge that samples the new high level:**
  - `deb` rises at edge E_D, where D=`DEBOUNCE_CYCLES`.
  - `pend` is set at E_(D+1).
  - State changes to DRIVE and `s`/`r` go high after E_(D+2).
- **Pulse duration:** the output stays high for exactly `PULSE_W` cycles. `busy` covers `PULSE_W`+1 cycles.
- **Back-to-back:** the minimum spacing between two output pulses is 2 cycles (HOLDOFF, then the next DRIVE). Worst-case service gap is therefore `PULSE_W`+1 cycles.
- **Conflict timing:** `conflict` is registered and goes high at the edge after IDLE sees both `pend` set.
- **Glitch rejection:** a glitch shorter than D samples never changes `deb`.

## Configuration
- **`SR_INPUT_SYNC_EN`** defined:
  - Each raw input passes through a 2-flop synchronizer, reset to 0, before the debouncer.
  - All latencies grow by 2 cycles.
- **`SR_INPUT_SYNC_EN`** undefined: the debouncer samples `set_in`/`clr_in` directly. Use this only when the inputs are already synchronous to `clk`.

## Structure
- **Package `sr_cond_pkg`:**
  - FSM state enum `sr_cond_state_t` (IDLE, DRIVE_S, DRIVE_R, HOLDOFF).
  - HOLDOFF length constant `SR_HOLDOFF_CYCLES`=1.
- **Sub-module `sr_debounce`:**
  - Parameter `DEBOUNCE_CYCLES`; includes the optional synchronizer.
  - Ports: `clk`, `rst`, `din`, `deb`, `rise`.
  - Instantiated twice, once per channel.
- **Top level:** holds the pend latches, FSM, pulse counter and output registers.

## Test plan
All scenarios use D=4 and `PULSE_W`=2 unless stated.
1. **Clean set.** `set_in` 0→1 and held → `s` high for edges 7–8 after E1 (2 cycles), `r`=0 throughout, `busy` high for 3 cycles.
2. **Bounce rejection.** `set_in` toggles 1,0,1,1,0 → no `s` pulse. The input is then held high for 4 samples → exactly one `s` pulse.
3. **Simultaneous request.** `set_in` and `clr_in` rise on the same edge → `conflict` high for 1 cycle; `s`=`r`=0; `busy` stays 0.
4. **Queued request.** `clr_in` becomes debounced while `s` is being driven → `r` pulse starts 2 cycles after `s` falls. `s` and `r` never overlap.
5. **Reset mid-pulse.** `rst` asserted in the first DRIVE_S cycle → `s`=0 after that edge, `busy`=0, and no pulse follows after reset is released.
6. **Synchronizer build, D=1, `PULSE_W`=1, `SR_INPUT_SYNC_EN` defined.** `set_in` rises → `s` high for 1 cycle after E5, versus after E3 without the macro.
